// File: rtl/neuron_mac_accum.sv
// ---------------------------------------------------------------------------
// neuron_mac_accum
//
// Multiply-accumulate stage for one neuron. It sits directly in front of the
// ReLU activation. One evaluation works as follows:
//   * A start pulse in IDLE samples a Q8.8 bias.
//   * N_INPUTS (activation, weight) pairs are streamed in over a valid/ready
//     interface.
//   * Their Q16.16 products are summed, together with the bias, in a wide
//     accumulator.
//   * The sum is rounded half-up to Q8.8 and saturated to 16 bits.
//   * The result is presented on a valid/ready output.
//
// Pipeline, timed from the edge E that accepts a beat:
//   E     operands captured into op_a_q/op_b_q
//   E+1   product registered into prod_q
//   E+2   product added into acc_q
// For the last beat, the FSM leaves ACCUM at E+1 and adds in DRAIN at E+2.
// ROUND then registers the narrowed result, so out_valid rises at E+3.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begins an evaluation from IDLE; samples bias
//   bias       in   signed Q8.8 bias
//   in_valid   in   in_data/weight pair valid
//   in_ready   out  a pair is accepted this cycle
//   in_data    in   signed Q8.8 activation
//   weight     in   signed Q8.8 weight
//   out_valid  out  out_data/sat hold a result
//   out_ready  in   downstream accepts the result
//   out_data   out  signed Q8.8 rounded and saturated result
//   sat        out  result was clipped (qualified by out_valid)
//   busy       out  FSM is not in IDLE
// ---------------------------------------------------------------------------
module neuron_mac_accum #(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sat,
  output logic              busy
);

  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_INPUTS);

  // Rounding constant (half of one output LSB).
  localparam logic signed [ACC_W-1:0] HALF_LSB =
    {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // Clip limits of the DATA_W-bit result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_DRAIN  = 3'd2,
    S_ROUND  = 3'd3,
    S_OUTPUT = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Beat counter.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operand stage.
  logic signed [DATA_W-1:0] op_a_q, op_a_d;
  logic signed [DATA_W-1:0] op_b_q, op_b_d;
  logic                     op_vld_q, op_vld_d;

  // Product stage.
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_vld_q, prod_vld_d;

  // Accumulator.
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Output registers.
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;

  // Combinational helpers.
  logic                     beat_fire;
  logic                     start_fire;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  round_sum;
  logic signed [ACC_W-1:0]  round_r;
  logic [DATA_W-1:0]        round_data;
  logic                     round_sat;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        // The counter reaches N_INPUTS on the last accepting edge. Leaving
        // one cycle later lets that beat's product reach prod_q before DRAIN
        // folds it into the accumulator.
        if (cnt_q == N_CNT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_valid_q && out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ACCUM: begin
        in_ready = (cnt_q < N_CNT);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;

  // -------------------------------------------------------------------------
  // Datapath: arithmetic
  // -------------------------------------------------------------------------
  assign beat_fire  = in_valid && in_ready;
  assign start_fire = (state_q == S_IDLE) && start;

  // Both operands are sign-extended to full product width first. The low
  // PROD_W bits of that product are the exact signed product.
  assign prod_full = $signed({{DATA_W{op_a_q[DATA_W-1]}}, op_a_q}) *
                     $signed({{DATA_W{op_b_q[DATA_W-1]}}, op_b_q});

  assign prod_ext = $signed({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});

  // Align the Q8.8 bias to the Q16.16 product scale.
  assign bias_ext = $signed({{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}},
                             bias, {FRAC_W{1'b0}}});

  // Round half up, then narrow with saturation.
  assign round_sum = acc_q + HALF_LSB;
  assign round_r   = round_sum >>> FRAC_W;

  always_comb begin
    round_data = round_r[DATA_W-1:0];
    round_sat  = 1'b0;
    if (round_r > RES_MAX) begin
      round_data = {1'b0, {(DATA_W-1){1'b1}}};
      round_sat  = 1'b1;
    end else if (round_r < RES_MIN) begin
      round_data = {1'b1, {(DATA_W-1){1'b0}}};
      round_sat  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_vld_d    = beat_fire;
    prod_d      = prod_q;
    prod_vld_d  = op_vld_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (start_fire) begin
      cnt_d = '0;
    end else if (beat_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (beat_fire) begin
      op_a_d = $signed(in_data);
      op_b_d = $signed(weight);
    end

    if (op_vld_q) begin
      prod_d = prod_full;
    end

    // The pipeline is always empty in IDLE, so a bias load never collides
    // with a pending product.
    if (start_fire) begin
      acc_d = bias_ext;
    end else if (prod_vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    if (state_q == S_ROUND) begin
      out_data_d  = round_data;
      sat_d       = round_sat;
      out_valid_d = 1'b1;
    end else if ((state_q == S_OUTPUT) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_vld_q    <= 1'b0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_vld_q    <= op_vld_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_accum
//
// Table-driven bench for neuron_mac_accum with N_INPUTS = 4.
//   * Each record holds the bias, four beats, flow-control knobs (input gaps,
//     output stall, stray start pulses) and the expected result.
//   * Expected results are pushed to a scoreboard queue when an evaluation
//     is started, and popped when the DUT presents its output.
//   * Cases that need N_INPUTS = 1 are expressed with the remaining beats
//     set to zero, which leaves the sum unchanged.
// ---------------------------------------------------------------------------
module tb_neuron_mac_accum;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] weight;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        sat;
  logic        busy;

  neuron_mac_accum #(
    .N_INPUTS(N),
    .DATA_W  (16),
    .FRAC_W  (8),
    .ACC_W   (40)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .weight   (weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sat      (sat),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [15:0]     bias;
    logic [3:0][15:0] a;
    logic [3:0][15:0] w;
    int              gap;       // idle cycles between beats
    int              stall;     // cycles out_ready is held low
    bit              mid_start; // pulse start during ACCUM
    bit              hs_start;  // pulse start with the output handshake
    logic [15:0]     exp_data;
    logic            exp_sat;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[12];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] b,
                              input logic [63:0] a, input logic [63:0] w,
                              input int gap, input int stall,
                              input bit ms, input bit hs,
                              input logic [15:0] ed, input logic es);
    vec_t v;
    v.name = n;  v.bias = b;  v.a = a;  v.w = w;
    v.gap = gap; v.stall = stall; v.mid_start = ms; v.hs_start = hs;
    v.exp_data = ed; v.exp_sat = es;
    return v;
  endfunction

  // Reference arithmetic, used for the random records only.
  function automatic exp_t model(input logic [15:0] b,
                                 input logic [3:0][15:0] a,
                                 input logic [3:0][15:0] w);
    exp_t   e;
    longint acc;
    longint r;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < N; i++) begin
      acc += longint'($signed(a[i])) * longint'($signed(w[i]));
    end
    r = (acc + 128) >>> 8;
    if (r > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (r < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = r[15:0];  e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    int   t;
    int   lat;

    e.data = v.exp_data;
    e.sat  = v.exp_sat;

    bias  = v.bias;
    start = 1'b1;
    step();
    start = 1'b0;
    bias  = 16'h0000;
    sb_q.push_back(e);
    chk({v.name, ".busy_after_start"}, 32'(busy), 32'd1);

    for (int b = 0; b < N; b++) begin
      if (b > 0) begin
        repeat (v.gap) begin
          in_valid = 1'b0;
          step();
        end
      end
      if (v.mid_start && b == 2) begin
        // A stray start with a different bias must not disturb ACCUM.
        start    = 1'b1;
        bias     = 16'h7FFF;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        bias  = 16'h0000;
      end
      in_valid = 1'b1;
      in_data  = v.a[b];
      weight   = v.w[b];
      t = 0;
      while (!in_ready && t < 20) begin
        step();
        t++;
      end
      if (!in_ready) chk({v.name, ".in_ready_timeout"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_data  = 16'h0000;
      weight   = 16'h0000;
    end

    // Sampled just after the edge that accepted the last beat.
    chk({v.name, ".in_ready_after_last"}, 32'(in_ready), 32'd0);

    out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({v.name, ".latency"}, 32'(lat), 32'd3);

    got = (sb_q.size() > 0) ? sb_q.pop_front() : e;
    chk({v.name, ".out_data"}, 32'(out_data), 32'(got.data));
    chk({v.name, ".sat"}, 32'(sat), 32'(got.sat));

    for (int s = 0; s < v.stall; s++) begin
      step();
      chk({v.name, ".stall_valid"}, 32'(out_valid), 32'd1);
      chk({v.name, ".stall_data"}, 32'(out_data), 32'(got.data));
      chk({v.name, ".stall_sat"}, 32'(sat), 32'(got.sat));
    end

    out_ready = 1'b1;
    if (v.hs_start) begin
      start = 1'b1;
      bias  = 16'h0100;
    end
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    bias      = 16'h0000;
    chk({v.name, ".valid_cleared"}, 32'(out_valid), 32'd0);
    chk({v.name, ".busy_cleared"}, 32'(busy), 32'd0);
    chk({v.name, ".in_ready_idle"}, 32'(in_ready), 32'd0);

    $display("txn %-14s bias=%h result=%h sat=%b required=%h/%b", v.name,
             v.bias, got.data, got.sat, e.data, e.sat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t rv;
    exp_t re;

    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    weight    = 16'h0000;
    out_ready = 1'b0;

    //            name            bias      a (beat3..beat0)        w (beat3..beat0)        gap stall ms hs exp      sat
    tbl[0]  = mk("basic",         16'h0000, {4{16'h0100}},          {4{16'h0200}},          0, 0, 0, 0, 16'h0800, 1'b0);
    tbl[1]  = mk("bias_neg",      16'hFF00, 64'h0,                  64'h0,                  0, 0, 0, 0, 16'hFF00, 1'b0);
    tbl[2]  = mk("sat_pos",       16'h0000, {4{16'h7FFF}},          {4{16'h7FFF}},          0, 0, 0, 0, 16'h7FFF, 1'b1);
    tbl[3]  = mk("sat_neg",       16'h0000, {4{16'h8000}},          {4{16'h7FFF}},          0, 0, 0, 0, 16'h8000, 1'b1);
    tbl[4]  = mk("round_up",      16'h0000, {48'h0, 16'h0001},      {48'h0, 16'h0080},      0, 0, 0, 0, 16'h0001, 1'b0);
    tbl[5]  = mk("round_neg_half",16'h0000, {48'h0, 16'h0001},      {48'h0, 16'hFF80},      0, 0, 0, 0, 16'h0000, 1'b0);
    tbl[6]  = mk("round_neg",     16'h0000, {48'h0, 16'h0001},      {48'h0, 16'hFF7F},      0, 0, 0, 0, 16'hFFFF, 1'b0);
    tbl[7]  = mk("max_exact",     16'h7FFF, 64'h0,                  64'h0,                  0, 0, 0, 0, 16'h7FFF, 1'b0);
    tbl[8]  = mk("min_exact",     16'h8000, 64'h0,                  64'h0,                  0, 0, 0, 0, 16'h8000, 1'b0);
    tbl[9]  = mk("max_plus_half", 16'h7FFF, {48'h0, 16'h0001},      {48'h0, 16'h0080},      0, 0, 0, 0, 16'h7FFF, 1'b1);
    tbl[10] = mk("mixed_gaps",    16'h0080, 64'h0100_0040_FF00_0180, 64'hFE00_0400_0300_0200, 2, 5, 0, 1, 16'hFF80, 1'b0);
    tbl[11] = mk("basic_flow",    16'h0000, {4{16'h0100}},          {4{16'h0200}},          2, 5, 1, 1, 16'h0800, 1'b0);

    // Reset state.
    step();
    step();
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.out_data", 32'(out_data), 32'd0);
    chk("reset.sat", 32'(sat), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle.busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i]);
    end

    // Random records, expectation from the reference arithmetic.
    for (int i = 0; i < 4; i++) begin
      rv = mk("random", 16'($urandom), {16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom)}, {16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom)}, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0, 1'b0);
      re = model(rv.bias, rv.a, rv.w);
      rv.exp_data = re.data;
      rv.exp_sat  = re.sat;
      run_vec(rv);
    end

    // Reset after two of four large beats. Outputs must clear immediately,
    // and the following evaluation must carry no trace of the aborted beats.
    bias  = 16'h0000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_data  = 16'h0400;
      weight   = 16'h0400;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.in_ready", 32'(in_ready), 32'd0);
    chk("abort.out_data", 32'(out_data), 32'd0);
    chk("abort.sat", 32'(sat), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("abort.no_output", 32'(out_valid), 32'd0);
    end
    run_vec(tbl[0]);

    chk("scoreboard.empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_accum.md
Name: neuron_mac_accum

Overview:
- Per-neuron multiply-accumulate stage sitting directly upstream of the ReLU activation.
- Streams N_INPUTS (activation, weight) pairs and adds a bias.
- Rounds and saturates the sum to one 16-bit signed Q8.8 word (bit 15 = sign) and presents it on a valid/ready output for the activation stage to consume.

Parameters:
- N_INPUTS, 16, pairs accumulated per neuron evaluation (1..255).
- DATA_W, 16, width of activation, weight, bias and result words.
- FRAC_W, 8, fractional bits of every DATA_W word (Q8.8).
- ACC_W, 40, accumulator width; must be ≥ 2*DATA_W + ceil(log2(N_INPUTS+1)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins an evaluation, samples bias.
- bias  in  DATA_W  signed Q8.8 bias, sampled when start is accepted.
- in_valid  in  1  in_data/weight pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_data  in  DATA_W  signed Q8.8 activation.
- weight  in  DATA_W  signed Q8.8 weight.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  signed Q8.8 result.
- sat  out  1  result was clipped; valid with out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE; in_ready, out_valid, sat and busy are 0; out_data=0; accumulator, product register and beat counter are 0.
- FSM: IDLE -> ACCUM -> DRAIN -> ROUND -> OUTPUT -> IDLE.
- IDLE:
  - start=1 loads acc = sign_extend(bias) << FRAC_W, clears the counter and goes to ACCUM.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1 while counter < N_INPUTS.
  - A beat transfers when in_valid && in_ready.
  - The product in_data*weight (signed, 2*DATA_W bits, Q16.16) is registered the cycle after transfer and added to acc (sign-extended to ACC_W) the following cycle.
  - Counter increments per transfer.
  - On the N_INPUTS-th transfer, in_ready drops the next cycle and the FSM enters DRAIN.
  - Gaps (in_valid=0) are allowed and do not add anything.
- DRAIN: one cycle; the last product is added to acc.
- ROUND: one cycle.
  - r = (acc + (1 << (FRAC_W-1))) >>> FRAC_W: round half up, arithmetic shift.
  - If r > 32767, out_data=0x7FFF and sat=1.
  - If r < -32768, out_data=0x8000 and sat=1.
  - Otherwise out_data=r[15:0] and sat=0.
  - Registered into out_data/sat; out_valid=1 entering OUTPUT.
- Latency: out_valid rises on the 3rd rising edge after the edge that accepted the last beat.
- OUTPUT:
  - out_data, sat and out_valid are held stable while out_ready=0.
  - When out_valid && out_ready, out_valid clears on that edge and the FSM returns to IDLE.
  - A start in that same cycle is ignored; start must be issued from IDLE.
- The accumulator never wraps: ACC_W covers the worst-case sum, so saturation happens only at the final narrowing.
- Reset mid-operation: all state is discarded immediately, with no partial result emitted.
- in_ready is 0 in IDLE, DRAIN, ROUND and OUTPUT.
- busy=1 from the edge accepting start until the edge completing the output handshake.

Test Plan:
- Basic sum (N_INPUTS=4): bias=0x0000; 4 beats of in_data=0x0100 (1.0), weight=0x0200 (2.0), back-to-back -> out_data=0x0800 (8.0), sat=0, out_valid 3 edges after the 4th accept.
- Bias only, negative (N_INPUTS=4): bias=0xFF00 (-1.0); all inputs 0x0000 -> out_data=0xFF00, sat=0; a downstream ReLU then yields 0x0000.
- Saturation (N_INPUTS=4):
  - 4 beats of 0x7FFF*0x7FFF -> out_data=0x7FFF, sat=1.
  - 4 beats of 0x8000*0x7FFF -> out_data=0x8000, sat=1.
- Rounding (N_INPUTS=1): bias=0; in_data=0x0001, weight=0x0080 (product = 0.5 LSB) -> out_data=0x0001.
  - Same with weight=0xFF80 -> out_data=0x0000.
- Flow control:
  - in_valid toggled 1,0,0,1,... -> same result as back-to-back, and in_ready=0 after the 4th beat.
  - out_ready held 0 for 5 cycles -> out_data/out_valid stable.
  - start pulsed mid-ACCUM -> ignored, result unchanged.
- Reset mid-operation: assert rst_n=0 after 2 of 4 beats -> outputs immediately 0 and busy=0.
  - A fresh start with the basic-sum stimulus then gives 0x0800, with no contribution from the aborted beats.
